// File: rtl/program_loader_pkg.sv
// Shared processor definitions: opcode constants, loader parameter defaults
// and the program-loader state encoding.
package program_loader_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERROR
  } loader_state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Little-endian byte-to-word assembler: four accepted bytes make one word,
// with a word-complete pulse on the cycle the fourth byte arrives.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  clr_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  word_done_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  // Bytes enter at the top so byte0 ends up in [7:0] after four shifts.
  assign word_o      = {byte_i, shift_q[DATA_WIDTH-1:8]};
  assign word_done_o = byte_valid_i && !clr_i && (cnt_q == 2'd3);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = word_o;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: 16-bit little-endian word count, then words
// assembled from bytes and written one per WRITE cycle to instruction memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  load_req,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  prog_ready,
  output logic                  load_err
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  loader_state_e         state_q, state_d;
  logic                  len_hi_q, len_hi_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

  logic                  accept;
  logic                  asm_valid;
  logic                  asm_done;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [15:0]           n_full;
  logic                  last_word;

  assign rx_ready   = (state_q == LEN) || (state_q == DATA);
  assign w_en       = (state_q == WRITE);
  assign prog_ready = (state_q == DONE);
  assign load_err   = (state_q == ERROR);
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;

  assign accept    = rx_valid && rx_ready;
  assign asm_valid = accept && (state_q == DATA);
  assign n_full    = {rx_data, n_q[7:0]};
  // With N = DEPTH the last index is DEPTH-1 and the increment wraps to 0.
  assign last_word = (32'(idx_q) == ({16'd0, n_q} - 32'd1));

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_word_assembler (
    .clk_i       (clk),
    .arst_i      (arst),
    .clr_i       (load_req),
    .byte_valid_i(asm_valid),
    .byte_i      (rx_data),
    .word_o      (asm_word),
    .word_done_o (asm_done)
  );

  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    idx_d    = idx_q;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (load_req) begin
      state_d  = LEN;
      len_hi_d = 1'b0;
      n_d      = '0;
      idx_d    = '0;
    end else begin
      unique case (state_q)
        LEN: begin
          if (accept) begin
            if (!len_hi_q) begin
              n_d[7:0] = rx_data;
              len_hi_d = 1'b1;
            end else begin
              n_d      = n_full;
              len_hi_d = 1'b0;
              if (n_full == 16'd0)                state_d = DONE;
              else if ({16'd0, n_full} > DEPTH)   state_d = ERROR;
              else                                state_d = DATA;
            end
          end
        end
        DATA: begin
          if (asm_done) begin
            state_d  = WRITE;
            w_addr_d = idx_q;
            w_data_d = asm_word;
          end
        end
        WRITE: begin
          idx_d   = idx_q + 1'b1;
          state_d = last_word ? DONE : DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      len_hi_q <= 1'b0;
      n_q      <= '0;
      idx_q    <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: length handling, word writes, aborts,
// asynchronous reset and a full-depth load with random byte gaps.
module tb_program_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          arst = 1'b0;
  logic          load_req = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic          prog_ready;
  logic          load_err;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  always #5 clk = ~clk;

  program_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .load_req  (load_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .w_en      (w_en),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .prog_ready(prog_ready),
    .load_err  (load_err)
  );

  always @(negedge clk) begin
    if (w_en === 1'b1) begin
      wq_addr.push_back(w_addr);
      wq_data.push_back(w_data);
    end
  end

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned t;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) send_byte(v[8*i +: 8], 0);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    #1 arst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, w_en, w_addr, w_data, prog_ready, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b wen=%b addr=%h data=%h pr=%b err=%b required all 0",
               rx_ready, w_en, w_addr, w_data, prog_ready, load_err);
    end
    repeat (2) @(negedge clk);
    arst = 1'b0;
    clear_log();
    rx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++;
    if (rx_ready !== 1'b0 || prog_ready !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_rx: rdy=%b pr=%b err=%b required 0 0 0", rx_ready, prog_ready, load_err);
    end
    checks++;
    if (wq_addr.size() != 0) begin
      errors++;
      $display("FAIL idle_no_write: writes=%0d required 0", wq_addr.size());
    end
  endtask

  task automatic test_two_words();
    clear_log();
    pulse_load();
    checks++;
    if (rx_ready !== 1'b1 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_enters_len: rdy=%b pr=%b required 1 0", rx_ready, prog_ready);
    end
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'h00100093);
    send_word(32'h00208133);
    checks++;
    if (w_en !== 1'b1 || w_addr !== 8'd1 || w_data !== 32'h00208133 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL second_write_cycle: wen=%b addr=%h data=%h pr=%b required 1 01 00208133 0",
               w_en, w_addr, w_data, prog_ready);
    end
    @(negedge clk);
    checks++;
    if (prog_ready !== 1'b1 || w_en !== 1'b0) begin
      errors++;
      $display("FAIL done_after_write: pr=%b wen=%b required 1 0", prog_ready, w_en);
    end
    checks++;
    if (w_addr !== 8'd1 || w_data !== 32'h00208133) begin
      errors++;
      $display("FAIL write_port_holds: addr=%h data=%h required 01 00208133", w_addr, w_data);
    end
    checks++;
    if (wq_addr.size() != 2) begin
      errors++;
      $display("FAIL two_word_count: writes=%0d required 2", wq_addr.size());
    end else if (wq_addr[0] !== 8'd0 || wq_data[0] !== 32'h00100093 ||
                 wq_addr[1] !== 8'd1 || wq_data[1] !== 32'h00208133) begin
      errors++;
      $display("FAIL two_word_data: got %h:%h %h:%h required 00:00100093 01:00208133",
               wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
    end
  endtask

  task automatic test_zero_length();
    clear_log();
    pulse_load();
    checks++;
    if (prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_clears_ready: pr=%b required 0", prog_ready);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (prog_ready !== 1'b1 || rx_ready !== 1'b0 || wq_addr.size() != 0) begin
      errors++;
      $display("FAIL zero_length: pr=%b rdy=%b writes=%0d required 1 0 0",
               prog_ready, rx_ready, wq_addr.size());
    end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_load();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (load_err !== 1'b1 || rx_ready !== 1'b0 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL oversize_error: err=%b rdy=%b pr=%b required 1 0 0", load_err, rx_ready, prog_ready);
    end
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++;
    if (load_err !== 1'b1 || wq_addr.size() != 0) begin
      errors++;
      $display("FAIL error_holds: err=%b writes=%0d required 1 0", load_err, wq_addr.size());
    end
    pulse_load();
    checks++;
    if (load_err !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_clears_error: err=%b rdy=%b required 0 1", load_err, rx_ready);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
  endtask

  task automatic test_abort_mid_load();
    clear_log();
    pulse_load();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_word(32'h44332211);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    pulse_load();
    checks++;
    if (rx_ready !== 1'b1 || w_en !== 1'b0 || prog_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_to_len: rdy=%b wen=%b pr=%b required 1 0 0", rx_ready, w_en, prog_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'hDDCCBBAA);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 2) begin
      errors++;
      $display("FAIL abort_write_count: writes=%0d required 2", wq_addr.size());
    end else if (wq_addr[0] !== 8'd0 || wq_data[0] !== 32'h44332211 ||
                 wq_addr[1] !== 8'd0 || wq_data[1] !== 32'hDDCCBBAA) begin
      errors++;
      $display("FAIL abort_write_data: got %h:%h %h:%h required 00:44332211 00:ddccbbaa",
               wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
    end
    checks++;
    if (prog_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_done: pr=%b required 1", prog_ready);
    end
  endtask

  task automatic test_abort_on_last_byte();
    clear_log();
    pulse_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    load_req = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    load_req = 1'b0;
    checks++;
    if (w_en !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_priority: wen=%b rdy=%b required 0 1", w_en, rx_ready);
    end
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_word(32'h0BADF00D);
    @(negedge clk);
    checks++;
    if (wq_addr.size() != 1) begin
      errors++;
      $display("FAIL abort_priority_count: writes=%0d required 1", wq_addr.size());
    end else if (wq_addr[0] !== 8'd0 || wq_data[0] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL abort_priority_data: got %h:%h required 00:0badf00d", wq_addr[0], wq_data[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_load();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_word(32'hCAFE1234);
    send_byte(8'h77, 0);
    send_byte(8'h88, 0);
    #2 arst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, w_en, w_addr, w_data, prog_ready, load_err} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: rdy=%b wen=%b addr=%h data=%h pr=%b err=%b required all 0",
               rx_ready, w_en, w_addr, w_data, prog_ready, load_err);
    end
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
    clear_log();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    checks++;
    if (wq_addr.size() != 0 || prog_ready !== 1'b0 || rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: writes=%0d pr=%b rdy=%b required 0 0 0",
               wq_addr.size(), prog_ready, rx_ready);
    end
  endtask

  task automatic test_full_depth_gaps();
    logic [7:0]  stream[1024];
    logic [31:0] exp_word;
    int          bad;
    for (int k = 0; k < 1024; k++) stream[k] = 8'((k * 37 + 11) & 255);
    clear_log();
    pulse_load();
    send_byte(8'h00, $urandom_range(0, 5));
    send_byte(8'h01, $urandom_range(0, 5));
    for (int k = 0; k < 1024; k++) send_byte(stream[k], $urandom_range(0, 5));
    @(negedge clk);
    checks++;
    if (prog_ready !== 1'b1 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL full_depth_done: pr=%b err=%b required 1 0", prog_ready, load_err);
    end
    checks++;
    if (wq_addr.size() != 256) begin
      errors++;
      $display("FAIL full_depth_count: writes=%0d required 256", wq_addr.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        exp_word = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
        if (wq_addr[i] !== 8'(i) || wq_data[i] !== exp_word) begin
          if (bad < 4)
            $display("FAIL full_depth_word%0d: got %h:%h required %h:%h",
                     i, wq_addr[i], wq_data[i], 8'(i), exp_word);
          bad++;
        end
      end
      if (bad != 0) errors++;
    end
    checks++;
    if (w_addr !== 8'hFF) begin
      errors++;
      $display("FAIL full_depth_last_addr: addr=%h required ff", w_addr);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_length();
    test_oversize();
    test_abort_mid_load();
    test_abort_on_last_byte();
    test_reset_mid_load();
    test_full_depth_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH  32  instruction word width
  ADDR_WIDTH  8  instruction-memory word-address width (depth 2**ADDR_WIDTH)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  arst  in  1  asynchronous, active-high reset
  load_req  in  1  one-cycle pulse: start or restart a program load
  rx_data  in  8  incoming program byte
  rx_valid  in  1  rx_data valid
  rx_ready  out  1  loader accepts a byte this cycle
  w_en  out  1  instruction-memory write strobe
  w_addr  out  ADDR_WIDTH  instruction-memory word address
  w_data  out  DATA_WIDTH  instruction word to write
  prog_ready  out  1  program fully loaded; processor may run
  load_err  out  1  declared word count exceeds memory depth
REQ-003 The design SHALL use one clock (clk) and an asynchronous, active-high reset (arst).

Function
REQ-004 The FSM SHALL have the states IDLE, LEN, DATA, WRITE, DONE and ERROR.
REQ-005 A byte SHALL transfer only on a rising edge where rx_valid and rx_ready are both 1.
REQ-006 rx_ready SHALL be 1 only in LEN and DATA; rx_data SHALL be ignored in every other state.
REQ-007 From IDLE, DONE or ERROR, load_req SHALL move the FSM to LEN.
REQ-008 On load_req, the byte count, word count, address counter, prog_ready and load_err SHALL all clear.
REQ-009 In LEN, two bytes SHALL form a 16-bit word count N, little-endian (first byte is the low byte).
REQ-010 After the second LEN byte, the FSM SHALL move to DONE if N=0.
REQ-011 After the second LEN byte, the FSM SHALL move to ERROR if N > 2**ADDR_WIDTH.
REQ-012 After the second LEN byte, the FSM SHALL move to DATA in all other cases.
REQ-013 In DATA, four bytes SHALL assemble one word, little-endian: byte0 to [7:0], byte3 to [31:24].
REQ-014 The 4th DATA byte SHALL move the FSM to WRITE.
REQ-015 WRITE SHALL last exactly one cycle with w_en=1, w_addr = current word index (first word 0), and w_data = the assembled word.
REQ-016 The write SHALL occur on the cycle after the 4th byte is accepted (latency 1).
REQ-017 After WRITE, the word index SHALL increment.
REQ-018 After WRITE, the FSM SHALL go to DONE if N words have been written, otherwise back to DATA.
REQ-019 When N = 2**ADDR_WIDTH, the last write SHALL use address 2**ADDR_WIDTH-1, and the index SHALL be allowed to wrap to 0 without any further write.
REQ-020 w_en SHALL be 0 in every state except WRITE.
REQ-021 w_addr and w_data SHALL hold their last values outside WRITE.
REQ-022 prog_ready SHALL be 1 exactly while in DONE; load_err SHALL be 1 exactly while in ERROR.
REQ-023 load_req in LEN, DATA or WRITE SHALL abort the load: no further w_en, partial word discarded, FSM to LEN.
REQ-024 If load_req coincides with the 4th DATA byte, the abort SHALL take priority and no write SHALL occur.
REQ-025 rx_valid held high with no load active SHALL have no effect.

Reset
REQ-026 While arst=1, the FSM SHALL be IDLE and all counters and the word register SHALL be 0.
REQ-027 While arst=1, the outputs SHALL be: rx_ready=0, w_en=0, w_addr=0, w_data=0, prog_ready=0, load_err=0.
REQ-028 Reset SHALL take effect immediately, without waiting for a clock edge.
REQ-029 Reset mid-load SHALL discard everything, and no w_en pulse SHALL follow deassertion.
REQ-030 After arst deasserts, the FSM SHALL remain in IDLE until load_req.

Structure
REQ-031 The loader state enum, DATA_WIDTH and ADDR_WIDTH defaults SHALL live in the shared processor package alongside the opcode constants.
REQ-032 The byte-to-word assembler SHALL be one sub-module, word_assembler: shift-in of 4 bytes, a 2-bit byte counter, and a word-complete pulse.
REQ-033 The FSM, the counters and the memory-write outputs SHALL stay in program_loader.
REQ-034 w_en, w_addr and w_data SHALL connect directly to the instruction-memory write port, and prog_ready SHALL connect to the processor's prog_ready input.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
  Scenario 1: load_req; bytes 02 00, then 93 00 10 00, then 33 81 20 00 -> w_en at addr 0 data 0x00100093, then addr 1 data 0x00208133; prog_ready=1 one cycle after the 2nd write.
  Scenario 2: load_req; bytes 00 00 -> prog_ready=1, no w_en.
  Scenario 3: ADDR_WIDTH=8; bytes 01 01 (N=257) -> load_err=1, rx_ready=0, no w_en; a later load_req clears load_err.
  Scenario 4: N=3 load with load_req pulsed after 6 DATA bytes -> only word 0 written; a new N=1 load writes addr 0.
  Scenario 5: arst asserted between the 2nd and 3rd byte of word 1 -> all outputs 0 immediately; no w_en after release; prog_ready=0.
  Scenario 6: random rx_valid gaps (0-5 idle cycles) on an N=256 load -> 256 writes at addresses 0..255 in order, data matches the byte stream, prog_ready=1.
